// File: rtl/line_fifo_pkg.sv
// Shared definitions for the multi-channel line FIFO controller:
// default geometry, depth/width helpers and packed-bus lane slicing.
package line_fifo_pkg;

    localparam int C_DEFAULT_DEPTH_WIDTH = 11;
    localparam int DEPTH = 2 ** C_DEFAULT_DEPTH_WIDTH;
    localparam int LVL_W = C_DEFAULT_DEPTH_WIDTH + 1;

    // Ceiling log2, for sizing indices from counts.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

    // Words per channel for a given address width.
    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// Slice lane idx (width w) out of a packed bus, lane 0 in the LSBs.
`ifndef LFC_LANE
`define LFC_LANE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

// File: rtl/line_fifo_ctrl_chan.sv
// Single-channel FIFO pointer/level/flag controller with optional
// first-word-fall-through prefetch into the external RAM's output register.
module line_fifo_ctrl_chan
    import line_fifo_pkg::*;
#(
    parameter int C_DEPTH_WIDTH      = 11,
    parameter int C_FWFT             = 0,
    parameter int C_ALMOST_FULL_NUM  = 2040,
    parameter int C_ALMOST_EMPTY_NUM = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     w_en,
    input  logic                     r_en,
    output logic                     ram_wen,
    output logic [C_DEPTH_WIDTH-1:0] waddr,
    output logic                     wfull,
    output logic                     almost_full,
    output logic                     ram_ren,
    output logic [C_DEPTH_WIDTH-1:0] raddr,
    output logic                     rempty,
    output logic                     almost_empty,
    output logic [C_DEPTH_WIDTH:0]   water_level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int LW = C_DEPTH_WIDTH + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(depth_of(C_DEPTH_WIDTH));
    localparam logic [LW-1:0] AF_LVL   = LW'(C_ALMOST_FULL_NUM);
    localparam logic [LW-1:0] AE_LVL   = LW'(C_ALMOST_EMPTY_NUM);

    logic [LW-1:0] wptr_q, wptr_d;
    logic [LW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          dout_valid_q, dout_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          clr, wa, pa, fetch;

    // Request/accept: w_en and r_en are requests that may be held any
    // length; a request is taken only in a cycle where the matching flag
    // (wfull / rempty) is low and no clear is pending, and the taken
    // transfer is visible as ram_wen / a level change in that same cycle.

    // Status flags come from registered state only.
    always_comb begin
        wfull        = (level_q == FULL_LVL);
        rempty       = (C_FWFT != 0) ? ~dout_valid_q : (level_q == '0);
        almost_full  = (level_q >= AF_LVL);
        almost_empty = (level_q <= AE_LVL);
    end

    // Accept decisions, RAM strobes and next-state computation.
    always_comb begin
        clr = rst | flush;
        wa  = w_en & ~wfull & ~clr;
        pa  = r_en & ~rempty & ~clr;
        if (C_FWFT != 0) begin
            // Keep the RAM output register loaded whenever unread data exists.
            fetch = (wptr_q != rptr_q) & (~dout_valid_q | pa) & ~clr;
        end else begin
            fetch = pa;
        end
        ram_wen      = wa;
        ram_ren      = fetch;
        wptr_d       = wptr_q + LW'(wa);
        rptr_d       = rptr_q + LW'(fetch);
        // Level includes a prefetched word until it is actually popped.
        level_d      = level_q + LW'(wa) - LW'(pa);
        dout_valid_d = (C_FWFT != 0) & (fetch | (dout_valid_q & ~pa));
        overflow_d   = overflow_q | (w_en & wfull);
        underflow_d  = underflow_q | (r_en & rempty);
        if (clr) begin
            wptr_d       = '0;
            rptr_d       = '0;
            level_d      = '0;
            dout_valid_d = 1'b0;
            overflow_d   = 1'b0;
            underflow_d  = 1'b0;
        end
    end

    assign waddr       = wptr_q[C_DEPTH_WIDTH-1:0];
    assign raddr       = rptr_q[C_DEPTH_WIDTH-1:0];
    assign water_level = level_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            level_q      <= level_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

endmodule

// File: rtl/line_fifo_ctrl_mc.sv
// Multi-channel line FIFO controller: one independent channel controller
// per image line RAM, with per-channel signals packed lane 0 in the LSBs.
module line_fifo_ctrl_mc
    import line_fifo_pkg::*;
#(
    parameter int C_CHANNELS         = 4,
    parameter int C_DEPTH_WIDTH      = 11,
    parameter int C_FWFT             = 0,
    parameter int C_ALMOST_FULL_NUM  = 2040,
    parameter int C_ALMOST_EMPTY_NUM = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [C_CHANNELS-1:0]                  flush,
    input  logic [C_CHANNELS-1:0]                  w_en,
    output logic [C_CHANNELS-1:0]                  ram_wen,
    output logic [C_CHANNELS*C_DEPTH_WIDTH-1:0]    waddr,
    output logic [C_CHANNELS-1:0]                  wfull,
    output logic [C_CHANNELS-1:0]                  almost_full,
    input  logic [C_CHANNELS-1:0]                  r_en,
    output logic [C_CHANNELS-1:0]                  ram_ren,
    output logic [C_CHANNELS*C_DEPTH_WIDTH-1:0]    raddr,
    output logic [C_CHANNELS-1:0]                  rempty,
    output logic [C_CHANNELS-1:0]                  almost_empty,
    output logic [C_CHANNELS*(C_DEPTH_WIDTH+1)-1:0] water_level,
    output logic [C_CHANNELS-1:0]                  overflow,
    output logic [C_CHANNELS-1:0]                  underflow
);

    for (genvar c = 0; c < C_CHANNELS; c++) begin : g_chan
        line_fifo_ctrl_chan #(
            .C_DEPTH_WIDTH      (C_DEPTH_WIDTH),
            .C_FWFT             (C_FWFT),
            .C_ALMOST_FULL_NUM  (C_ALMOST_FULL_NUM),
            .C_ALMOST_EMPTY_NUM (C_ALMOST_EMPTY_NUM)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .flush        (flush[c]),
            .w_en         (w_en[c]),
            .r_en         (r_en[c]),
            .ram_wen      (ram_wen[c]),
            .waddr        (`LFC_LANE(waddr, c, C_DEPTH_WIDTH)),
            .wfull        (wfull[c]),
            .almost_full  (almost_full[c]),
            .ram_ren      (ram_ren[c]),
            .raddr        (`LFC_LANE(raddr, c, C_DEPTH_WIDTH)),
            .rempty       (rempty[c]),
            .almost_empty (almost_empty[c]),
            .water_level  (`LFC_LANE(water_level, c, C_DEPTH_WIDTH + 1)),
            .overflow     (overflow[c]),
            .underflow    (underflow[c])
        );
    end

endmodule

// File: tb/tb_line_fifo_ctrl_mc.sv
// Bench for line_fifo_ctrl_mc: a standard-read and an FWFT instance share
// the same stimulus; behavioural word queues predict status and read data.
module tb_line_fifo_ctrl_mc;

    localparam int C   = 4;
    localparam int AW  = 4;
    localparam int DEP = 16;
    localparam int AFN = 14;
    localparam int AEN = 4;

    typedef struct packed {
        logic           wen;
        logic [AW-1:0]  waddr;
        logic           ren;
        logic [AW-1:0]  raddr;
        logic           full;
        logic           empty;
        logic           af;
        logic           ae;
        logic [AW:0]    lvl;
        logic           ov;
        logic           un;
    } st_t;

    // Lanes 0..3: standard instance channels, lanes 4..7: FWFT instance.
    typedef st_t [7:0] rec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [C-1:0]  flush, w_en, r_en;

    logic [C-1:0]        ram_wen_s, wfull_s, af_s, ram_ren_s, rempty_s, ae_s, ov_s, un_s;
    logic [C*AW-1:0]     waddr_s, raddr_s;
    logic [C*(AW+1)-1:0] wl_s;
    logic [C-1:0]        ram_wen_f, wfull_f, af_f, ram_ren_f, rempty_f, ae_f, ov_f, un_f;
    logic [C*AW-1:0]     waddr_f, raddr_f;
    logic [C*(AW+1)-1:0] wl_f;

    line_fifo_ctrl_mc #(
        .C_CHANNELS(C), .C_DEPTH_WIDTH(AW), .C_FWFT(0),
        .C_ALMOST_FULL_NUM(AFN), .C_ALMOST_EMPTY_NUM(AEN)
    ) dut_std (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en),
        .ram_wen(ram_wen_s), .waddr(waddr_s), .wfull(wfull_s), .almost_full(af_s),
        .r_en(r_en), .ram_ren(ram_ren_s), .raddr(raddr_s), .rempty(rempty_s),
        .almost_empty(ae_s), .water_level(wl_s), .overflow(ov_s), .underflow(un_s)
    );

    line_fifo_ctrl_mc #(
        .C_CHANNELS(C), .C_DEPTH_WIDTH(AW), .C_FWFT(1),
        .C_ALMOST_FULL_NUM(AFN), .C_ALMOST_EMPTY_NUM(AEN)
    ) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en),
        .ram_wen(ram_wen_f), .waddr(waddr_f), .wfull(wfull_f), .almost_full(af_f),
        .r_en(r_en), .ram_ren(ram_ren_f), .raddr(raddr_f), .rempty(rempty_f),
        .almost_empty(ae_f), .water_level(wl_f), .overflow(ov_f), .underflow(un_f)
    );

    // ---------------- external RAM models ----------------
    logic [7:0] wdata   [C];
    logic [7:0] ram_s   [C][DEP];
    logic [7:0] ram_f   [C][DEP];
    logic [7:0] rdata_s [C];
    logic [7:0] rdata_f [C];
    logic [C-1:0] rvalid_s;

    always @(posedge clk) begin
        for (int c = 0; c < C; c++) begin
            if (ram_wen_s[c]) ram_s[c][waddr_s[c*AW +: AW]] <= wdata[c];
            if (ram_ren_s[c]) rdata_s[c] <= ram_s[c][raddr_s[c*AW +: AW]];
            if (ram_wen_f[c]) ram_f[c][waddr_f[c*AW +: AW]] <= wdata[c];
            if (ram_ren_f[c]) rdata_f[c] <= ram_f[c][raddr_f[c*AW +: AW]];
        end
        rvalid_s <= ram_ren_s;
    end

    // ---------------- reference model + scoreboard ----------------
    logic [7:0] mq [8][$];   // words currently held by each lane's FIFO
    logic [7:0] dq [8][$];   // popped words awaiting appearance on RAM output
    int  wcnt [8];
    int  rcnt [8];
    bit  outv [8];           // FWFT: head word sitting in the RAM output register
    bit  ovf  [8];
    bit  unf  [8];
    rec_t st_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // One clock of stimulus; predicts this cycle's outputs, then advances the model.
    task automatic step(input logic [C-1:0] we, input logic [C-1:0] re,
                        input logic [C-1:0] fl, input logic r);
        rec_t e;
        int   c, sz;
        bit   fw, full, empty, clr, wa, pa, ren;
        @(negedge clk);
        cyc   = cyc + 1;
        rst   = r;
        w_en  = we;
        r_en  = re;
        flush = fl;
        for (int k = 0; k < C; k++) wdata[k] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) begin
            c     = i % C;
            fw    = (i >= C);
            sz    = mq[i].size();
            full  = (sz == DEP);
            empty = fw ? !outv[i] : (sz == 0);
            clr   = r || fl[c];
            wa    = we[c] && !full && !clr;
            pa    = re[c] && !empty && !clr;
            if (fw) ren = !clr && ((sz - (outv[i] ? 1 : 0)) > 0) && (!outv[i] || pa);
            else    ren = pa;
            e[i].wen   = wa;
            e[i].waddr = AW'(wcnt[i] % DEP);
            e[i].ren   = ren;
            e[i].raddr = AW'(rcnt[i] % DEP);
            e[i].full  = full;
            e[i].empty = empty;
            e[i].af    = (sz >= AFN);
            e[i].ae    = (sz <= AEN);
            e[i].lvl   = (AW+1)'(sz);
            e[i].ov    = ovf[i];
            e[i].un    = unf[i];
            if (clr) begin
                mq[i].delete();
                wcnt[i] = 0;
                rcnt[i] = 0;
                outv[i] = 0;
                ovf[i]  = 0;
                unf[i]  = 0;
            end else begin
                if (we[c] && full) ovf[i] = 1;
                if (re[c] && empty) unf[i] = 1;
                if (pa) dq[i].push_back(mq[i].pop_front());
                if (wa) begin
                    mq[i].push_back(wdata[c]);
                    wcnt[i] = wcnt[i] + 1;
                end
                if (ren) rcnt[i] = rcnt[i] + 1;
                if (fw) outv[i] = ren || (outv[i] && !pa);
            end
        end
        st_q.push_back(e);
    endtask

    task automatic rand_phase(input int n, input int pw, input int pr, input int pf);
        logic [C-1:0] we, re, fl;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < C; c++) begin
                we[c] = (int'($urandom_range(0, 99)) < pw);
                re[c] = (int'($urandom_range(0, 99)) < pr);
                fl[c] = (int'($urandom_range(0, 99)) < pf);
            end
            step(we, re, fl, 1'b0);
        end
    endtask

    function automatic st_t get_st(input int i);
        st_t s;
        int  c;
        c = i % C;
        if (i < C) begin
            s.wen = ram_wen_s[c]; s.waddr = waddr_s[c*AW +: AW];
            s.ren = ram_ren_s[c]; s.raddr = raddr_s[c*AW +: AW];
            s.full = wfull_s[c];  s.empty = rempty_s[c];
            s.af = af_s[c];       s.ae = ae_s[c];
            s.lvl = wl_s[c*(AW+1) +: (AW+1)];
            s.ov = ov_s[c];       s.un = un_s[c];
        end else begin
            s.wen = ram_wen_f[c]; s.waddr = waddr_f[c*AW +: AW];
            s.ren = ram_ren_f[c]; s.raddr = raddr_f[c*AW +: AW];
            s.full = wfull_f[c];  s.empty = rempty_f[c];
            s.af = af_f[c];       s.ae = ae_f[c];
            s.lvl = wl_f[c*(AW+1) +: (AW+1)];
            s.ov = ov_f[c];       s.un = un_f[c];
        end
        return s;
    endfunction

    // Monitor: compares each cycle's status and any read word the DUT presents.
    initial begin
        rec_t       e;
        st_t        a;
        bit         present;
        logic [7:0] got, want;
        forever begin
            @(negedge clk);
            #3;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                for (int i = 0; i < 8; i++) begin
                    a = get_st(i);
                    checks = checks + 1;
                    if (a !== e[i]) begin
                        errors = errors + 1;
                        $display("FAIL status lane%0d cyc%0d got wen=%b wa=%0d ren=%b ra=%0d full=%b empty=%b af=%b ae=%b lvl=%0d ov=%b un=%b exp wen=%b wa=%0d ren=%b ra=%0d full=%b empty=%b af=%b ae=%b lvl=%0d ov=%b un=%b",
                                 i, cyc, a.wen, a.waddr, a.ren, a.raddr, a.full, a.empty, a.af, a.ae, a.lvl, a.ov, a.un,
                                 e[i].wen, e[i].waddr, e[i].ren, e[i].raddr, e[i].full, e[i].empty, e[i].af, e[i].ae, e[i].lvl, e[i].ov, e[i].un);
                    end
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (i < C) present = rvalid_s[i];
                else present = r_en[i-C] && !rempty_f[i-C] && !flush[i-C] && !rst;
                if (present) begin
                    checks = checks + 1;
                    got = (i < C) ? rdata_s[i] : rdata_f[i-C];
                    if (dq[i].size() == 0) begin
                        errors = errors + 1;
                        $display("FAIL rdata lane%0d cyc%0d got %h with no word expected", i, cyc, got);
                    end else begin
                        want = dq[i].pop_front();
                        if (got !== want) begin
                            errors = errors + 1;
                            $display("FAIL rdata lane%0d cyc%0d got %h exp %h", i, cyc, got, want);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        flush = '0;
        w_en  = '0;
        r_en  = '0;
        for (int k = 0; k < C; k++) wdata[k] = '0;
        repeat (2) @(posedge clk);

        // Reset state while idle.
        repeat (2) step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Channel 0: fill to full, one extra write, drain with one extra pop.
        repeat (17) step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        repeat (17) step(4'b0000, 4'b0001, 4'b0000, 1'b0);

        // Full with simultaneous write and pop.
        repeat (16) step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(4'b0001, 4'b0001, 4'b0000, 1'b0);
        repeat (16) step(4'b0000, 4'b0001, 4'b0000, 1'b0);
        repeat (2) step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Empty with simultaneous write and pop, then streaming across wrap.
        step(4'b0001, 4'b0001, 4'b0000, 1'b0);
        repeat (100) step(4'b0001, 4'b0001, 4'b0000, 1'b0);
        repeat (20) step(4'b0000, 4'b0001, 4'b0000, 1'b0);

        // Channel 1: eight writes, settle, then r_en held for back-to-back pops.
        repeat (8) step(4'b0010, 4'b0000, 4'b0000, 1'b0);
        repeat (3) step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        repeat (10) step(4'b0000, 4'b0010, 4'b0000, 1'b0);

        // Independent random traffic, with occasional flushes.
        rand_phase(150, 70, 40, 0);
        rand_phase(150, 50, 55, 2);
        rand_phase(40, 80, 20, 0);

        // Flush channel 2 while it requests both a write and a pop.
        step(4'b1111, 4'b1111, 4'b0100, 1'b0);
        repeat (2) step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Reset in the middle of traffic.
        rand_phase(30, 60, 40, 0);
        step(4'b1111, 4'b1111, 4'b0000, 1'b1);
        repeat (3) step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // More traffic, then drain every channel.
        rand_phase(60, 60, 50, 0);
        repeat (40) step(4'b0000, 4'b1111, 4'b0000, 1'b0);
        repeat (3) step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        @(negedge clk);
        #5;
        for (int i = 0; i < 8; i++) begin
            checks = checks + 1;
            if (dq[i].size() != 0) begin
                errors = errors + 1;
                $display("FAIL drain lane%0d got %0d words never presented exp 0", i, dq[i].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
